mouse_cursor_tracker: RTL and testbench
=======================================

# mouse_cursor_tracker

Consumes the level-style movement and button flags from the PS/2 mouse handler and turns them into an on-screen cursor position for the VGA renderer. It synchronises the flags (they originate in the PS2_CLK domain) into CLK and rate-limits movement with an auto-repeat counter. It clamps the cursor to the visible area and produces single-cycle click events with the position latched at click time.

## Interface
- H_RES, 640: visible width in pixels.
- V_RES, 480: visible height in pixels.
- CURSOR_SIZE, 8: cursor square edge. Maximum positions are X_MAX = H_RES-CURSOR_SIZE and Y_MAX = V_RES-CURSOR_SIZE.
- INIT_X, 316 / INIT_Y, 236: cursor position after reset.
- STEP, 1: pixels moved per step (1..CURSOR_SIZE).
- MOVE_DIV, 250000: CLK cycles between repeated steps while a direction is held (≥2).
- CLK  in  1  system/pixel clock.
- RESET  in  1  synchronous, active-high reset.
- left_click, right_click  in  1  button levels (async to CLK).
- mouse_up, mouse_down, mouse_left, mouse_right  in  1  direction levels (async to CLK).
- cursor_x  out  10  cursor left edge, 0..X_MAX.
- cursor_y  out  10  cursor top edge, 0..Y_MAX; 0 is the top of the screen.
- left_held  out  1  synchronised left button level.
- left_pulse, right_pulse  out  1  one-cycle press events.
- click_x, click_y  out  10 each  cursor position captured on the most recent left_pulse.

## Operation
- Synchronisation:
  - Each of the 6 inputs passes through a 2-flop synchroniser; only stage-2 values are used.
  - Synchroniser flops reset to 0.
- Click edge detect:
  - left_pulse = 1 for one cycle when synced left goes 0→1. right_pulse likewise for right.
  - left_held follows synced left.
  - On left_pulse, click_x/click_y load the cursor_x/cursor_y value in effect before any same-cycle move.
- Per-axis direction:
  - x: right-only → +STEP; left-only → −STEP; both or neither → 0.
  - y: down-only → +STEP; up-only → −STEP; both or neither → 0.
  - "Active" means at least one synced direction input is high, even if the axis nets to 0.
- FSM, 2 states:
  - IDLE: repeat counter held at 0. If active, apply one step this cycle and go to MOVING with counter = 0.
  - MOVING, not active: go to IDLE, counter ← 0, no step.
  - MOVING, active: counter increments. When counter == MOVE_DIV−1, apply a step with the current directions and set counter ← 0.
  - Direction changes while in MOVING do not restart the counter.
- Step arithmetic (widen to 11 bits signed, then clamp):
  - x' = min(max(x+dx, 0), X_MAX); same for y with Y_MAX.
  - Never wraps. At the boundary, a step toward the edge leaves the position saturated.
- Reset values:
  - cursor_x = INIT_X, cursor_y = INIT_Y.
  - click_x = INIT_X, click_y = INIT_Y.
  - left_held = left_pulse = right_pulse = 0.
  - FSM = IDLE, counter = 0.
- Reset mid-operation:
  - Everything returns to reset values the next cycle.
  - An input still held through reset is treated as a new press/move once RESET deasserts (synchronisers restart from 0).

## Timing
- Input sampled high at edge k → synchroniser stage 2 at k+1 → registered effect at edge k+2.
- A new press gives left_pulse high during the cycle after edge k+2. A new move gives the updated cursor_x/y visible after edge k+2.
- Repeat steps while held: at k+2+MOVE_DIV, k+2+2·MOVE_DIV, …
- Releasing all directions at synced edge j puts the FSM in IDLE after edge j. A re-press then steps immediately (2 cycles after sync) with no repeat wait.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Run with MOVE_DIV=4 and the other parameters at default.
- Reset: hold RESET 3 cycles → cursor=(316,236), click=(316,236), all pulses 0.
- Single right tap held exactly 4 cycles → one step (cursor_x=317) at edge k+2, a second step at k+6 only if still synced high; no movement after release.
- mouse_left held from x=2 with STEP=1 for 5 steps → x = 1, 0, 0, 0, 0; no wrap to 1023.
- Down held from y = Y_MAX−1 → y = 472, then stays 472. Up and down both high → y unchanged while x still moves with right.
- left_click rises while the cursor is at (100,50) and moving right the same cycle → left_pulse one cycle, click=(100,50), cursor_x=101. left_held stays 1 while the input is held; no second pulse.
- RESET asserted during MOVING with mouse_right held → cursor=(316,236) the next cycle; after release of RESET the first step occurs 2 cycles later (x=317).

Source files
------------

// File: rtl/mouse_cursor_tracker.sv
// Cursor position tracker: synchronises PS/2 movement/button levels into CLK,
// steps the cursor with auto-repeat, clamps it on screen and emits click events.
module mouse_cursor_tracker #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int CURSOR_SIZE = 8,
  parameter int INIT_X      = 316,
  parameter int INIT_Y      = 236,
  parameter int STEP        = 1,
  parameter int MOVE_DIV    = 250000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       left_click,
  input  logic       right_click,
  input  logic       mouse_up,
  input  logic       mouse_down,
  input  logic       mouse_left,
  input  logic       mouse_right,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       left_held,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic [9:0] click_x,
  output logic [9:0] click_y
);

  localparam int X_MAX = H_RES - CURSOR_SIZE;
  localparam int Y_MAX = V_RES - CURSOR_SIZE;
  localparam int CW    = $clog2(MOVE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_DIV - 1);

  typedef enum logic {IDLE, MOVING} state_t;

  // bit order: left, right, up, down, left-dir, right-dir
  logic [5:0]        raw;
  logic [5:0]        s1_q, s1_d, s2_q, s2_d;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [9:0]        click_x_q, click_x_d, click_y_q, click_y_d;
  logic              lh_q, lh_d, rh_q, rh_d, lp_q, lp_d, rp_q, rp_d;

  logic              l_s, r_s, up_s, dn_s, lf_s, rt_s, active, step;
  logic signed [10:0] dx, dy, nx, ny;

  function automatic logic [9:0] clamp(input logic signed [10:0] v, input int max);
    if (v < 11'sd0)        clamp = '0;
    else if (int'(v) > max) clamp = 10'(max);
    else                   clamp = v[9:0];
  endfunction

  assign raw = {left_click, right_click, mouse_up, mouse_down, mouse_left, mouse_right};
  assign {l_s, r_s, up_s, dn_s, lf_s, rt_s} = s2_q;
  assign active = up_s | dn_s | lf_s | rt_s;

  always_comb begin
    s1_d = raw;
    s2_d = s1_q;

    dx = '0;
    if (rt_s && !lf_s)      dx = 11'(STEP);
    else if (lf_s && !rt_s) dx = -11'(STEP);
    dy = '0;
    if (dn_s && !up_s)      dy = 11'(STEP);
    else if (up_s && !dn_s) dy = -11'(STEP);

    step    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (active) begin
          step    = 1'b1;
          state_d = MOVING;
        end
      end
      MOVING: begin
        if (!active) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          step  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    nx  = $signed({1'b0, x_q}) + dx;
    ny  = $signed({1'b0, y_q}) + dy;
    x_d = step ? clamp(nx, X_MAX) : x_q;
    y_d = step ? clamp(ny, Y_MAX) : y_q;

    lh_d = l_s;
    rh_d = r_s;
    lp_d = l_s & ~lh_q;
    rp_d = r_s & ~rh_q;
    // click position is the pre-step cursor of the press cycle
    click_x_d = lp_d ? x_q : click_x_q;
    click_y_d = lp_d ? y_q : click_y_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_q      <= '0;
      s2_q      <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      x_q       <= 10'(INIT_X);
      y_q       <= 10'(INIT_Y);
      click_x_q <= 10'(INIT_X);
      click_y_q <= 10'(INIT_Y);
      lh_q      <= 1'b0;
      rh_q      <= 1'b0;
      lp_q      <= 1'b0;
      rp_q      <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      click_x_q <= click_x_d;
      click_y_q <= click_y_d;
      lh_q      <= lh_d;
      rh_q      <= rh_d;
      lp_q      <= lp_d;
      rp_q      <= rp_d;
    end
  end

  assign cursor_x    = x_q;
  assign cursor_y    = y_q;
  assign click_x     = click_x_q;
  assign click_y     = click_y_q;
  assign left_held   = lh_q;
  assign left_pulse  = lp_q;
  assign right_pulse = rp_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Scoreboard bench for mouse_cursor_tracker (MOVE_DIV=4): expectations are
// queued against a cycle number when stimulus is driven and checked on negedge.
module tb_mouse_cursor_tracker;

  localparam int X_MAX = 632;
  localparam int Y_MAX = 472;
  localparam int SX = 0, SY = 1, SCX = 2, SCY = 3, SLP = 4, SRP = 5, SLH = 6;

  logic       CLK = 1'b0, RESET = 1'b1;
  logic       left_click = 0, right_click = 0;
  logic       mouse_up = 0, mouse_down = 0, mouse_left = 0, mouse_right = 0;
  logic [9:0] cursor_x, cursor_y, click_x, click_y;
  logic       left_held, left_pulse, right_pulse;

  mouse_cursor_tracker #(.MOVE_DIV(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .left_click(left_click), .right_click(right_click),
    .mouse_up(mouse_up), .mouse_down(mouse_down),
    .mouse_left(mouse_left), .mouse_right(mouse_right),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .left_held(left_held), .left_pulse(left_pulse), .right_pulse(right_pulse),
    .click_x(click_x), .click_y(click_y)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    string tag;
    int    sel;
    int    val;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0;
  int mx = 316, my = 236;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input string tag, input int sel, input int val);
    exp_t e;
    e.cyc = c; e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  function automatic int probe(input int sel);
    case (sel)
      SX:      probe = int'(cursor_x);
      SY:      probe = int'(cursor_y);
      SCX:     probe = int'(click_x);
      SCY:     probe = int'(click_y);
      SLP:     probe = int'(left_pulse);
      SRP:     probe = int'(right_pulse);
      default: probe = int'(left_held);
    endcase
  endfunction

  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        chk({sb[i].tag, "_late"}, cyc, sb[i].cyc);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, probe(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  function automatic int clampi(input int v, input int max);
    clampi = (v < 0) ? 0 : (v > max) ? max : v;
  endfunction

  task automatic set_dirs(input bit u, input bit d, input bit l, input bit r);
    mouse_up = u; mouse_down = d; mouse_left = l; mouse_right = r;
  endtask

  // Hold a direction set from IDLE for n_steps steps, then release before the next repeat.
  task automatic move(input bit u, input bit d, input bit l, input bit r, input int n_steps);
    int n, dx, dy;
    n  = cyc;
    dx = (r && !l) ? 1 : (l && !r) ? -1 : 0;
    dy = (d && !u) ? 1 : (u && !d) ? -1 : 0;
    push(n + 2, "pre_x", SX, mx);
    push(n + 2, "pre_y", SY, my);
    set_dirs(u, d, l, r);
    for (int i = 0; i < n_steps; i++) begin
      mx = clampi(mx + dx, X_MAX);
      my = clampi(my + dy, Y_MAX);
      push(n + 3 + 4 * i, "step_x", SX, mx);
      push(n + 3 + 4 * i, "step_y", SY, my);
    end
    repeat (4 * n_steps - 1) @(negedge CLK);
    set_dirs(0, 0, 0, 0);
    push(cyc + 5, "rel_x", SX, mx);
    push(cyc + 5, "rel_y", SY, my);
    repeat (6) @(negedge CLK);
  endtask

  initial begin
    int n;
    @(negedge CLK);
    push(cyc + 1, "rst_x", SX, 316);   push(cyc + 1, "rst_y", SY, 236);
    push(cyc + 2, "rst_cx", SCX, 316); push(cyc + 2, "rst_cy", SCY, 236);
    push(cyc + 2, "rst_lp", SLP, 0);   push(cyc + 2, "rst_rp", SRP, 0);
    push(cyc + 2, "rst_lh", SLH, 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    push(cyc + 2, "idle_x", SX, 316);
    repeat (3) @(negedge CLK);

    // right tap sampled on exactly 4 edges: one step only
    n = cyc;
    push(n + 2, "tap_pre", SX, 316);
    push(n + 3, "tap_step", SX, 317);
    push(n + 7, "tap_one", SX, 317);
    push(n + 10, "tap_idle", SX, 317);
    mouse_right = 1'b1;
    repeat (4) @(negedge CLK);
    mouse_right = 1'b0;
    repeat (8) @(negedge CLK);
    mx = 317;

    // left to the edge and beyond: 2,1,0,0,0,0 with no wrap
    move(0, 0, 1, 0, 319);
    push(cyc + 1, "x_floor", SX, 0);
    // down past Y_MAX
    move(0, 1, 0, 0, 237);
    push(cyc + 1, "y_ceiling", SY, 472);
    // up+down cancel while right still moves x
    move(1, 1, 0, 1, 3);
    // travel to (100,50)
    move(0, 0, 0, 1, 97);
    move(1, 0, 0, 0, 422);
    push(cyc + 1, "at_x", SX, 100);
    push(cyc + 1, "at_y", SY, 50);
    repeat (2) @(negedge CLK);

    // left press coinciding with a right step
    n = cyc;
    push(n + 2, "lp_pre", SLP, 0);
    push(n + 3, "lp", SLP, 1);
    push(n + 3, "lp_cx", SCX, 100);
    push(n + 3, "lp_cy", SCY, 50);
    push(n + 3, "lp_x", SX, 101);
    push(n + 3, "lp_lh", SLH, 1);
    push(n + 4, "lp_once", SLP, 0);
    push(n + 4, "lp_lh2", SLH, 1);
    left_click = 1'b1; mouse_right = 1'b1;
    repeat (3) @(negedge CLK);
    mouse_right = 1'b0;
    repeat (5) @(negedge CLK);
    push(n + 9, "lp_none", SLP, 0);
    push(n + 9, "lp_cx2", SCX, 100);
    push(n + 9, "lp_x2", SX, 101);
    push(n + 10, "lh_hold", SLH, 1);
    push(n + 11, "lh_rel", SLH, 0);
    left_click = 1'b0;
    repeat (6) @(negedge CLK);
    mx = 101;

    // right button pulse
    n = cyc;
    push(n + 2, "rp_pre", SRP, 0);
    push(n + 3, "rp", SRP, 1);
    push(n + 4, "rp_once", SRP, 0);
    right_click = 1'b1;
    repeat (5) @(negedge CLK);
    right_click = 1'b0;
    repeat (4) @(negedge CLK);

    // reset during MOVING with right held
    n = cyc;
    push(n + 3, "rm_step", SX, mx + 1);
    mouse_right = 1'b1;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    push(n + 5, "mr_x", SX, 316);   push(n + 5, "mr_y", SY, 236);
    push(n + 5, "mr_cx", SCX, 316); push(n + 5, "mr_cy", SCY, 236);
    push(n + 5, "mr_lp", SLP, 0);
    @(negedge CLK);
    RESET = 1'b0;
    push(n + 6, "mr_hold1", SX, 316);
    push(n + 7, "mr_hold2", SX, 316);
    push(n + 8, "mr_step", SX, 317);
    repeat (3) @(negedge CLK);
    mouse_right = 1'b0;
    repeat (6) @(negedge CLK);

    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
